// File: rtl/pattern_rec_table.sv
// Record table with a sequential default-pattern fill engine.
// Indexed writes override the default for their index during a fill.
module pattern_rec_table #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int VAL_W = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_req,
    input  logic [KEY_W-1:0] fill_key,
    input  logic [VAL_W-1:0] fill_val,
    output logic             fill_busy,
    output logic             fill_done,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [VAL_W-1:0] wr_val,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic [VAL_W-1:0] rd_val,
    output logic             rd_vld,
    output logic [IDX_W:0]   vld_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] ptr_q;
    logic [KEY_W-1:0] shd_key_q;
    logic [VAL_W-1:0] shd_val_q;

    logic [KEY_W-1:0] key_q [DEPTH];
    logic [VAL_W-1:0] val_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] ovr_q;

    logic             fill_start;
    logic             fill_step;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] step_hit;
    logic [IDX_W+1:0] cnt_sum;
    logic [KEY_W-1:0] rd_key_d;
    logic [VAL_W-1:0] rd_val_d;
    logic             rd_vld_d;

    always_comb begin
        state_d    = state_q;
        fill_start = 1'b0;
        fill_step  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    fill_start = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                fill_step = 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-entry decode; out-of-range indices match no entry and drop out.
    always_comb begin
        wr_hit   = '0;
        step_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i]   = wr_en && (wr_idx == IDX_W'(i));
            step_hit[i] = fill_step && (ptr_q == IDX_W'(i))
                          && !ovr_q[i] && !wr_hit[i];
        end
    end

    always_comb begin
        rd_key_d = '0;
        rd_val_d = '0;
        rd_vld_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_key_d = key_q[i];
                rd_val_d = val_q[i];
                rd_vld_d = vld_q[i];
            end
        end
    end

    // Each edge can newly validate at most one write and one fill entry.
    always_comb begin
        cnt_sum = {1'b0, vld_cnt}
                + (IDX_W+2)'($countones((wr_hit | step_hit) & ~vld_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            shd_key_q <= '0;
            shd_val_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_start) begin
                ptr_q     <= '0;
                shd_key_q <= fill_key;
                shd_val_q <= fill_val;
            end else if (fill_step) begin
                ptr_q <= (state_d == DONE) ? '0 : ptr_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            vld_q <= '0;
            ovr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    key_q[i] <= wr_key;
                    val_q[i] <= wr_val;
                    vld_q[i] <= 1'b1;
                end else if (step_hit[i]) begin
                    key_q[i] <= shd_key_q;
                    val_q[i] <= shd_val_q;
                    vld_q[i] <= 1'b1;
                end
            end
            if (fill_start) begin
                ovr_q <= '0;
            end else if (state_q == FILL) begin
                ovr_q <= ovr_q | wr_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key  <= '0;
            rd_val  <= '0;
            rd_vld  <= 1'b0;
            vld_cnt <= '0;
        end else begin
            rd_key <= rd_key_d;
            rd_val <= rd_val_d;
            rd_vld <= rd_vld_d;
            if (cnt_sum > (IDX_W+2)'(DEPTH)) begin
                vld_cnt <= (IDX_W+1)'(DEPTH);
            end else begin
                vld_cnt <= cnt_sum[IDX_W:0];
            end
        end
    end

    assign fill_busy = (state_q == FILL);
    assign fill_done = (state_q == DONE);

endmodule

// File: tb/tb_pattern_rec_table.sv
// Randomised bench for pattern_rec_table at DEPTH=8 and DEPTH=6,
// both instances driven by the same stimulus and checked against a model.
module tb_pattern_rec_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fill_req = 1'b0;
    logic [31:0] fill_key = '0;
    logic [63:0] fill_val = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [31:0] wr_key = '0;
    logic [63:0] wr_val = '0;
    logic [2:0]  rd_idx = '0;

    logic        busy [2];
    logic        done [2];
    logic [31:0] rk   [2];
    logic [63:0] rv   [2];
    logic        rl   [2];
    logic [3:0]  cnt  [2];

    always #5 clk = ~clk;

    pattern_rec_table #(.DEPTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n),
        .fill_req(fill_req), .fill_key(fill_key), .fill_val(fill_val),
        .fill_busy(busy[0]), .fill_done(done[0]),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_val(wr_val),
        .rd_idx(rd_idx), .rd_key(rk[0]), .rd_val(rv[0]), .rd_vld(rl[0]),
        .vld_cnt(cnt[0])
    );

    pattern_rec_table #(.DEPTH(6)) u_d6 (
        .clk(clk), .rst_n(rst_n),
        .fill_req(fill_req), .fill_key(fill_key), .fill_val(fill_val),
        .fill_busy(busy[1]), .fill_done(done[1]),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_val(wr_val),
        .rd_idx(rd_idx), .rd_key(rk[1]), .rd_val(rv[1]), .rd_vld(rl[1]),
        .vld_cnt(cnt[1])
    );

    int dp [2] = '{8, 6};
    int n_cmp = 0;
    int n_err = 0;

    // Reference: table contents, override marks, and fill age
    // (0 = idle, 1..D = fill cycle, D+1 = done pulse).
    logic [31:0] mk  [2][8];
    logic [63:0] mv  [2][8];
    bit          mvl [2][8];
    bit          mov [2][8];
    int          age [2];
    logic [31:0] sk  [2];
    logic [63:0] sv  [2];
    logic [31:0] erk [2];
    logic [63:0] erv [2];
    bit          erl [2];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                mk[m][i] = '0; mv[m][i] = '0; mvl[m][i] = 0; mov[m][i] = 0;
            end
            age[m] = 0; sk[m] = '0; sv[m] = '0;
            erk[m] = '0; erv[m] = '0; erl[m] = 0;
        end
    endfunction

    function automatic void model_step(int m);
        int d = dp[m];
        int a = age[m];
        if (int'(rd_idx) < d) begin
            erk[m] = mk[m][rd_idx]; erv[m] = mv[m][rd_idx]; erl[m] = mvl[m][rd_idx];
        end else begin
            erk[m] = '0; erv[m] = '0; erl[m] = 0;
        end
        if (a >= 1 && a <= d) begin
            int i = a - 1;
            if (!mov[m][i] && !(wr_en && int'(wr_idx) == i)) begin
                mk[m][i] = sk[m]; mv[m][i] = sv[m]; mvl[m][i] = 1;
            end
            age[m] = a + 1;
        end else if (a == d + 1) begin
            age[m] = 0;
        end else if (fill_req) begin
            age[m] = 1; sk[m] = fill_key; sv[m] = fill_val;
            for (int i = 0; i < 8; i++) mov[m][i] = 0;
        end
        if (wr_en && int'(wr_idx) < d) begin
            mk[m][wr_idx] = wr_key; mv[m][wr_idx] = wr_val; mvl[m][wr_idx] = 1;
            if (a >= 1 && a <= d) mov[m][wr_idx] = 1;
        end
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            int c = 0;
            string p = $sformatf("d%0d_", dp[m]);
            for (int i = 0; i < dp[m]; i++) c += int'(mvl[m][i]);
            check({p, "busy"}, busy[m], (age[m] >= 1 && age[m] <= dp[m]));
            check({p, "done"}, done[m], (age[m] == dp[m] + 1));
            check({p, "rd_key"}, rk[m], erk[m]);
            check({p, "rd_val"}, rv[m], erv[m]);
            check({p, "rd_vld"}, rl[m], erl[m]);
            check({p, "vld_cnt"}, cnt[m], c);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge: async assert mid-cycle, release next negedge.
    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_cnt8", cnt[0], 0);
        check("rst_done6", done[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // n = interval index after the request edge at which sampling resumes.
    task automatic measure(input int start_n, input string tag);
        int dn [2] = '{0, 0};
        int bz [2] = '{0, 0};
        for (int n = start_n; n <= start_n + 20; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (busy[m]) bz[m]++;
                if (done[m] && dn[m] == 0) dn[m] = n;
            end
            if (dn[0] != 0 && dn[1] != 0) break;
            cycle();
        end
        check({tag, "_done_at8"}, dn[0], 9);
        check({tag, "_done_at6"}, dn[1], 7);
        if (start_n == 1) begin
            check({tag, "_busy8"}, bz[0], 8);
            check({tag, "_busy6"}, bz[1], 6);
        end
        cycle();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        check("reset_vld_cnt", cnt[0], 0);
        rst_n = 1'b1;

        fill_key = 32'd10; fill_val = 64'd10; fill_req = 1'b1;
        cycle();
        fill_req = 1'b0; fill_key = 32'hdead; fill_val = 64'hbeef;
        measure(1, "fill10");
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            cycle();
            check("fill10_key8", rk[0], 10);
            check("fill10_key6", rk[1], (i < 6) ? 10 : 0);
        end
        check("fill10_cnt8", cnt[0], 8);
        check("fill10_cnt6", cnt[1], 6);

        pulse_reset();
        fill_key = '0; fill_val = '0; fill_req = 1'b1;
        cycle();
        fill_req = 1'b0; wr_en = 1'b1;
        wr_idx = 3'd3; wr_key = 32'd42; wr_val = 64'd1;
        cycle();
        wr_idx = 3'd4; wr_key = 32'd29; wr_val = 64'd2;
        cycle();
        wr_idx = 3'd2; wr_key = 32'd77; wr_val = 64'd3; rd_idx = 3'd2;
        cycle();
        check("collide_rd_key", rk[0], 0);
        check("collide_rd_vld", rl[0], 0);
        wr_idx = 3'd0; wr_key = 32'd5; wr_val = 64'd7; fill_req = 1'b1;
        cycle();
        wr_en = 1'b0; fill_req = 1'b0;
        measure(5, "ovr");
        wr_en = 1'b1; wr_idx = 3'd7; wr_key = 32'd99; wr_val = 64'd9;
        cycle();
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            cycle();
        end
        rd_idx = 3'd3;
        cycle();
        check("ovr_idx3_key", rk[0], 42);
        check("ovr_idx3_vld", rl[0], 1);
        rd_idx = 3'd0;
        cycle();
        check("behind_idx0_val", rv[0], 7);
        rd_idx = 3'd6;
        cycle();
        check("oob_rd6_vld", rl[1], 0);

        fill_key = 32'h1234; fill_val = 64'h5678; fill_req = 1'b1;
        cycle();
        fill_req = 1'b0;
        cycle();
        cycle();
        pulse_reset();
        for (int i = 0; i < 12; i++) cycle();

        for (int t = 0; t < 3000; t++) begin
            fill_req = ($urandom % 16) == 0;
            fill_key = $urandom;
            fill_val = {$urandom, $urandom};
            wr_en    = ($urandom % 4) == 0;
            wr_idx   = 3'($urandom % 8);
            wr_key   = $urandom;
            wr_val   = {$urandom, $urandom};
            rd_idx   = 3'($urandom % 8);
            cycle();
            if (($urandom % 400) == 0) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
